mod5_run_ctrl: RTL and testbench

MOD5_RUN_CTRL -- requirements
Module: mod5_run_ctrl

---
 rtl/mod5_pkg.sv | 25 ++
 rtl/mod5_core.sv | 38 +++
 rtl/mod5_run_ctrl.sv | 132 +++++++++++++
 tb/tb_mod5_run_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mod5_pkg.sv
// Shared definitions for the mod-5 run controller: state encoding, counter
// modulus and width, and the modulo increment used by the counter core.
package mod5_pkg;

    localparam int MOD   = 5;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] mod_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_W'(MOD - 1)) begin
            r = '0;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod5_core.sv
// Mod-5 counter core: clears on clr, advances on en, and flags the 4->0 step
// so the controller can count completed wraps.
module mod5_core
    import mod5_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] out,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // clr wins over en so an abort or completion always lands on zero.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = mod_inc(cnt_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign out  = cnt_reg;
    assign wrap = en && (cnt_reg == CNT_W'(MOD - 1));

endmodule

// File: rtl/mod5_run_ctrl.sv
// Run controller: counts a requested number of full 0..4 cycles with pause,
// abort and a one-cycle done pulse on normal completion.
module mod5_run_ctrl
    import mod5_pkg::*;
#(
    parameter int WRAP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WRAP_W-1:0] wraps,
    input  logic              pause,
    input  logic              abort,
    output logic [2:0]        out,
    output logic              tc,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt
);

    state_t            state_reg;
    state_t            state_next;
    logic [WRAP_W-1:0] target_reg;
    logic [WRAP_W-1:0] target_next;
    logic [WRAP_W-1:0] wrap_cnt_reg;
    logic [WRAP_W-1:0] wrap_cnt_next;
    logic [WRAP_W-1:0] wrap_cnt_inc;

    logic             core_en;
    logic             core_clr;
    logic             core_wrap;
    logic [CNT_W-1:0] core_out;

    mod5_core u_core (
        .clk   (clk),
        .reset (reset),
        .en    (core_en),
        .clr   (core_clr),
        .out   (core_out),
        .wrap  (core_wrap)
    );

    assign wrap_cnt_inc = wrap_cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            target_reg   <= '0;
            wrap_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            target_reg   <= target_next;
            wrap_cnt_reg <= wrap_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        target_next   = target_reg;
        wrap_cnt_next = wrap_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && (wraps != '0)) begin
                    state_next    = ST_RUN;
                    target_next   = wraps;
                    wrap_cnt_next = '0;
                end
            end
            ST_RUN: begin
                // abort beats pause, which beats wrap completion
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (pause) begin
                    state_next = ST_HOLD;
                end else if (core_wrap) begin
                    wrap_cnt_next = wrap_cnt_inc;
                    if (wrap_cnt_inc == target_reg) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (!pause) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        core_en  = 1'b0;
        core_clr = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        tc       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                core_clr = 1'b1;
            end
            ST_RUN: begin
                busy     = 1'b1;
                tc       = (core_out == CNT_W'(MOD - 1));
                core_clr = abort;
                core_en  = !abort && !pause;
            end
            ST_HOLD: begin
                // leaving HOLD never advances: that is the resume bubble
                busy     = 1'b1;
                core_clr = abort;
            end
            ST_DONE: begin
                done     = 1'b1;
                core_clr = 1'b1;
            end
            default: begin
                core_clr = 1'b1;
            end
        endcase
    end

    assign out      = core_out;
    assign wrap_cnt = wrap_cnt_reg;

endmodule

// File: tb/tb_mod5_run_ctrl.sv
// Scoreboard bench for mod5_run_ctrl: directed stimulus pushes the expected
// post-edge outputs, a monitor pops and compares them after every edge.
module tb_mod5_run_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] wraps;
    logic       pause;
    logic       abort;
    logic [2:0] out;
    logic       tc;
    logic       busy;
    logic       done;
    logic [3:0] wrap_cnt;

    typedef struct packed {
        logic [2:0] out;
        logic       tc;
        logic       busy;
        logic       done;
        logic [3:0] wc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mod5_run_ctrl #(.WRAP_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .wraps    (wraps),
        .pause    (pause),
        .abort    (abort),
        .out      (out),
        .tc       (tc),
        .busy     (busy),
        .done     (done),
        .wrap_cnt (wrap_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, got, want);
        end
    endtask

    // Monitor: every edge with a pending expectation is a transaction.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cyc++;
            $display("cyc %0d out=%0d tc=%0d busy=%0d done=%0d wrap_cnt=%0d",
                     cyc, out, tc, busy, done, wrap_cnt);
            chk("out", int'(out), int'(e.out));
            chk("tc", int'(tc), int'(e.tc));
            chk("busy", int'(busy), int'(e.busy));
            chk("done", int'(done), int'(e.done));
            chk("wrap_cnt", int'(wrap_cnt), int'(e.wc));
        end
    end

    // Drive inputs for the next edge and queue the outputs expected after it.
    task automatic step(input logic s, input logic [3:0] w, input logic p,
                        input logic a, input logic r,
                        input logic [2:0] eo, input logic et, input logic eb,
                        input logic ed, input logic [3:0] ewc);
        exp_t e;
        @(negedge clk);
        start = s;
        wraps = w;
        pause = p;
        abort = a;
        reset = r;
        e.out  = eo;
        e.tc   = et;
        e.busy = eb;
        e.done = ed;
        e.wc   = ewc;
        exp_q.push_back(e);
    endtask

    // Free-running RUN cycles k = first..last after a start.
    task automatic run_span(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0,
                 3'(k % 5), (k % 5) == 4, 1'b1, 1'b0, 4'(k / 5));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        wraps = 4'd0;
        pause = 1'b0;
        abort = 1'b0;

        // reset, two cycles
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // wraps=2: ten busy cycles, done on the eleventh
        step(1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
        run_span(1, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

        // wraps=1 with a 3-cycle pause at out==2
        step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        run_span(1, 2);
        step(0, 0, 1, 0, 0, 2, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 2, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 2, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 2, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 3, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 4, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // wraps=3, abort at wrap_cnt=1 / out==3
        step(1, 3, 0, 0, 0, 0, 0, 1, 0, 0);
        run_span(1, 8);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // start with wraps=0 ignored; start during RUN and DONE ignored
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 3, 0, 0, 0, 1, 0, 1, 0, 0);
        step(1, 3, 0, 0, 0, 2, 0, 1, 0, 0);
        step(1, 3, 0, 0, 0, 3, 0, 1, 0, 0);
        step(1, 3, 0, 0, 0, 4, 1, 1, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // reset mid-run together with pause and abort
        step(1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
        run_span(1, 3);
        step(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset during DONE clears wrap_cnt
        step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        run_span(1, 4);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // maximum run: wraps=15, 75 busy cycles
        step(1, 15, 0, 0, 0, 0, 0, 1, 0, 0);
        run_span(1, 74);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 15);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 15);

        repeat (3) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
